// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if: AHB-Lite slave front-end for the SRAM controller.
// Revision: 1.0 - initial release.
`default_nettype none

module ahb_sram_slave_if #(
  parameter int MEM_BYTES  = 2048,
  parameter int AHB_DWIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  aresetn,
  input  logic                  HSEL,
  input  logic                  HREADYIN,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [19:0]           HADDR,
  input  logic [AHB_DWIDTH-1:0] HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [AHB_DWIDTH-1:0] HRDATA,
  output logic                  ahbsram_req,
  output logic                  ahbsram_write,
  output logic [2:0]            ahbsram_size,
  output logic [19:0]           ahbsram_addr,
  output logic [AHB_DWIDTH-1:0] ahbsram_wdata,
  input  logic                  sramahb_ack,
  input  logic [AHB_DWIDTH-1:0] sramahb_rdata,
  input  logic                  BUSY
);

  localparam logic [19:0] C_MEM_LIMIT = 20'(MEM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_WDATA, S_BWAIT, S_REQ, S_ACKW, S_RDATA, S_ERR1, S_ERR2
  } state_t;

  state_t                  state_q, state_d;
  logic                    write_q, write_d;
  logic [2:0]              size_q, size_d;
  logic [19:0]             addr_q, addr_d;
  logic [AHB_DWIDTH-1:0]   wdata_q, wdata_d;
  logic                    w_valid, w_err, w_accept;
  logic                    w_unused;

  assign w_valid  = HSEL & HREADYIN & HTRANS[1];
  assign w_err    = (HSIZE > 3'b010) | (HADDR >= C_MEM_LIMIT);
  assign w_unused = HTRANS[0];

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    HREADYOUT   = 1'b0;
    HRESP       = 1'b0;
    ahbsram_req = 1'b0;
    w_accept    = 1'b0;

    case (state_q)
      S_IDLE: begin
        HREADYOUT = 1'b1;
        w_accept  = 1'b1;
      end
      S_WDATA: begin
        wdata_d = HWDATA;
        state_d = BUSY ? S_BWAIT : S_REQ;
      end
      S_BWAIT: begin
        if (!BUSY) state_d = S_REQ;
      end
      S_REQ: begin
        ahbsram_req = 1'b1;
        state_d     = S_ACKW;
      end
      S_ACKW: begin
        // Writes complete in the ack cycle itself; reads need one more cycle for data.
        if (sramahb_ack) begin
          if (write_q) begin
            HREADYOUT = 1'b1;
            w_accept  = 1'b1;
          end else begin
            state_d = S_RDATA;
          end
        end
      end
      S_RDATA: begin
        HREADYOUT = 1'b1;
        w_accept  = 1'b1;
      end
      S_ERR1: begin
        HRESP   = 1'b1;
        state_d = S_ERR2;
      end
      S_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
        w_accept  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Any cycle with HREADYOUT high may take a new address phase without a bubble.
    if (w_accept) begin
      state_d = S_IDLE;
      if (w_valid) begin
        write_d = HWRITE;
        size_d  = HSIZE;
        addr_d  = HADDR;
        if (w_err)       state_d = S_ERR1;
        else if (HWRITE) state_d = S_WDATA;
        else if (BUSY)   state_d = S_BWAIT;
        else             state_d = S_REQ;
      end
    end
  end

  always_ff @(posedge HCLK or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      size_q  <= 3'b000;
      addr_q  <= 20'h0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign ahbsram_write = write_q;
  assign ahbsram_size  = size_q;
  assign ahbsram_addr  = addr_q;
  assign ahbsram_wdata = wdata_q;
  assign HRDATA        = sramahb_rdata;

endmodule

`default_nettype wire

// File: tb/tb_ahb_sram_slave_if.sv
// tb_ahb_sram_slave_if: directed self-checking bench with a small SRAM controller model.
// Revision: 1.0 - initial release.
`default_nettype none

module tb_ahb_sram_slave_if;

  logic        HCLK = 1'b0;
  logic        aresetn;
  logic        HSEL, HREADYIN, HWRITE, BUSY;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [19:0] HADDR;
  logic [31:0] HWDATA;
  logic        HREADYOUT, HRESP, ahbsram_req, ahbsram_write;
  logic [31:0] HRDATA, ahbsram_wdata, sramahb_rdata;
  logic [2:0]  ahbsram_size;
  logic [19:0] ahbsram_addr;
  logic        sramahb_ack;

  logic        ack_m, ack_force, ctl_en;
  logic [31:0] rdata_m;
  logic [31:0] mem [0:511];

  int checks = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  ahb_sram_slave_if #(.MEM_BYTES(2048), .AHB_DWIDTH(32)) dut (
    .HCLK(HCLK), .aresetn(aresetn), .HSEL(HSEL), .HREADYIN(HREADYIN),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HADDR(HADDR),
    .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .ahbsram_req(ahbsram_req), .ahbsram_write(ahbsram_write),
    .ahbsram_size(ahbsram_size), .ahbsram_addr(ahbsram_addr),
    .ahbsram_wdata(ahbsram_wdata), .sramahb_ack(sramahb_ack),
    .sramahb_rdata(sramahb_rdata), .BUSY(BUSY)
  );

  assign sramahb_ack   = ack_m | ack_force;
  assign sramahb_rdata = rdata_m;

  // Controller model: ack one cycle after req, read data valid the cycle after ack.
  always @(posedge HCLK) begin
    if (!aresetn) begin
      ack_m <= 1'b0;
    end else begin
      ack_m <= ctl_en & ahbsram_req;
      if (ack_m) begin
        if (ahbsram_write) begin
          case (ahbsram_size)
            3'b000:  mem[ahbsram_addr[10:2]][8*ahbsram_addr[1:0] +: 8] <= ahbsram_wdata[8*ahbsram_addr[1:0] +: 8];
            3'b001:  mem[ahbsram_addr[10:2]][16*ahbsram_addr[1] +: 16] <= ahbsram_wdata[16*ahbsram_addr[1] +: 16];
            default: mem[ahbsram_addr[10:2]] <= ahbsram_wdata;
          endcase
        end
        rdata_m <= mem[ahbsram_addr[10:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_phase(input logic wr, input logic [2:0] sz, input logic [19:0] a);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HSIZE = sz; HADDR = a;
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  initial begin
    aresetn = 1'b0; HSEL = 1'b0; HREADYIN = 1'b1; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b000; HADDR = 20'h0; HWDATA = 32'h0; BUSY = 1'b0;
    ack_force = 1'b0; ctl_en = 1'b1; rdata_m = 32'h0;
    #1;
    check("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    check("rst_hresp",     {31'h0, HRESP},     32'h0);
    check("rst_req",       {31'h0, ahbsram_req}, 32'h0);
    check("rst_addr",      {12'h0, ahbsram_addr}, 32'h0);
    tick(); tick();
    aresetn = 1'b1;
    tick();

    // Word write 0x010 = DEADBEEF
    addr_phase(1'b1, 3'b010, 20'h010);
    check("wr_c0_ready", {31'h0, HREADYOUT}, 32'h1);
    tick();
    bus_idle(); HWDATA = 32'hDEADBEEF;
    check("wr_c1_ready", {31'h0, HREADYOUT}, 32'h0);
    check("wr_c1_req",   {31'h0, ahbsram_req}, 32'h0);
    tick();
    check("wr_c2_req",   {31'h0, ahbsram_req}, 32'h1);
    check("wr_c2_ready", {31'h0, HREADYOUT}, 32'h0);
    check("wr_c2_addr",  {12'h0, ahbsram_addr}, 32'h010);
    check("wr_c2_size",  {29'h0, ahbsram_size}, 32'h2);
    check("wr_c2_write", {31'h0, ahbsram_write}, 32'h1);
    check("wr_c2_wdata", ahbsram_wdata, 32'hDEADBEEF);
    tick();
    check("wr_c3_ready", {31'h0, HREADYOUT}, 32'h1);
    check("wr_c3_hresp", {31'h0, HRESP}, 32'h0);
    check("wr_c3_req",   {31'h0, ahbsram_req}, 32'h0);
    tick();

    // Word read 0x010
    addr_phase(1'b0, 3'b010, 20'h010);
    tick();
    bus_idle();
    check("rd_c1_req",   {31'h0, ahbsram_req}, 32'h1);
    check("rd_c1_ready", {31'h0, HREADYOUT}, 32'h0);
    tick();
    check("rd_c2_ready", {31'h0, HREADYOUT}, 32'h0);
    check("rd_c2_req",   {31'h0, ahbsram_req}, 32'h0);
    tick();
    check("rd_c3_ready", {31'h0, HREADYOUT}, 32'h1);
    check("rd_c3_rdata", HRDATA, 32'hDEADBEEF);
    tick();

    // Back-to-back: byte write 0x004 then read 0x004 in the write's completion cycle
    addr_phase(1'b1, 3'b000, 20'h004);
    tick();
    bus_idle(); HWDATA = 32'h000000AA;
    tick();
    check("b2b_wr_req", {31'h0, ahbsram_req}, 32'h1);
    tick();
    check("b2b_wr_done", {31'h0, HREADYOUT}, 32'h1);
    addr_phase(1'b0, 3'b000, 20'h004);
    tick();
    bus_idle();
    check("b2b_rd_req",   {31'h0, ahbsram_req}, 32'h1);
    check("b2b_rd_write", {31'h0, ahbsram_write}, 32'h0);
    check("b2b_rd_addr",  {12'h0, ahbsram_addr}, 32'h004);
    tick();
    check("b2b_rd_wait", {31'h0, HREADYOUT}, 32'h0);
    tick();
    check("b2b_rd_ready", {31'h0, HREADYOUT}, 32'h1);
    check("b2b_rd_byte",  {24'h0, HRDATA[7:0]}, 32'hAA);
    tick();

    // BUSY held high for cycles 1..5 of a word write
    addr_phase(1'b1, 3'b010, 20'h008);
    tick();
    bus_idle(); HWDATA = 32'h12345678; BUSY = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) BUSY = 1'b0;
      check($sformatf("busy_c%0d_req", c), {31'h0, ahbsram_req}, 32'h0);
      check($sformatf("busy_c%0d_ready", c), {31'h0, HREADYOUT}, 32'h0);
      tick();
    end
    check("busy_c7_req",   {31'h0, ahbsram_req}, 32'h1);
    check("busy_c7_wdata", ahbsram_wdata, 32'h12345678);
    tick();
    check("busy_c8_ready", {31'h0, HREADYOUT}, 32'h1);
    tick();

    // Unsupported size
    addr_phase(1'b0, 3'b011, 20'h020);
    tick();
    bus_idle();
    check("sz_err1_ready", {31'h0, HREADYOUT}, 32'h0);
    check("sz_err1_hresp", {31'h0, HRESP}, 32'h1);
    check("sz_err1_req",   {31'h0, ahbsram_req}, 32'h0);
    tick();
    check("sz_err2_ready", {31'h0, HREADYOUT}, 32'h1);
    check("sz_err2_hresp", {31'h0, HRESP}, 32'h1);
    check("sz_err2_req",   {31'h0, ahbsram_req}, 32'h0);
    tick();
    check("sz_after_hresp", {31'h0, HRESP}, 32'h0);

    // Out-of-range address (first byte past the memory)
    addr_phase(1'b1, 3'b010, 20'h00800);
    tick();
    bus_idle();
    check("oor_err1_ready", {31'h0, HREADYOUT}, 32'h0);
    check("oor_err1_hresp", {31'h0, HRESP}, 32'h1);
    check("oor_err1_req",   {31'h0, ahbsram_req}, 32'h0);
    tick();
    check("oor_err2_ready", {31'h0, HREADYOUT}, 32'h1);
    check("oor_err2_hresp", {31'h0, HRESP}, 32'h1);
    check("oor_err2_req",   {31'h0, ahbsram_req}, 32'h0);
    tick();

    // Last in-range word is accepted
    addr_phase(1'b0, 3'b010, 20'h007FC);
    tick();
    bus_idle();
    check("edge_req",   {31'h0, ahbsram_req}, 32'h1);
    check("edge_hresp", {31'h0, HRESP}, 32'h0);
    tick(); tick();
    check("edge_ready", {31'h0, HREADYOUT}, 32'h1);
    tick();

    // Reset asserted while waiting for ack
    ctl_en = 1'b0;
    addr_phase(1'b0, 3'b010, 20'h010);
    tick();
    bus_idle();
    check("rstm_req", {31'h0, ahbsram_req}, 32'h1);
    tick();
    check("rstm_ackw_ready", {31'h0, HREADYOUT}, 32'h0);
    aresetn = 1'b0;
    #1;
    check("rstm_ready", {31'h0, HREADYOUT}, 32'h1);
    check("rstm_hresp", {31'h0, HRESP}, 32'h0);
    check("rstm_req0",  {31'h0, ahbsram_req}, 32'h0);
    check("rstm_write", {31'h0, ahbsram_write}, 32'h0);
    check("rstm_size",  {29'h0, ahbsram_size}, 32'h0);
    check("rstm_addr",  {12'h0, ahbsram_addr}, 32'h0);
    check("rstm_wdata", ahbsram_wdata, 32'h0);
    #2;
    aresetn = 1'b1;
    tick();
    ack_force = 1'b1;
    check("late_ack_ready", {31'h0, HREADYOUT}, 32'h1);
    check("late_ack_req",   {31'h0, ahbsram_req}, 32'h0);
    tick();
    ack_force = 1'b0;
    check("late_ack_ready2", {31'h0, HREADYOUT}, 32'h1);
    check("late_ack_req2",   {31'h0, ahbsram_req}, 32'h0);
    ctl_en = 1'b1;

    // Normal read after the reset
    addr_phase(1'b0, 3'b010, 20'h010);
    tick();
    bus_idle();
    check("post_rst_req", {31'h0, ahbsram_req}, 32'h1);
    tick(); tick();
    check("post_rst_ready", {31'h0, HREADYOUT}, 32'h1);
    check("post_rst_rdata", HRDATA, 32'hDEADBEEF);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
